// File: rtl/pipe_ctrl_if.sv
// Hazard/stall interface between the pipeline datapath and pipe_ctrl.
// The master modport drives the hazard inputs, and the slave modport is the controller side.
interface pipe_ctrl_if #(
  parameter int NSTAGES = 5
);
  logic               i_ICache_Miss;
  logic               i_DCache_Miss;
  logic               i_LoadUse;
  logic               i_Redirect;
  logic               i_Fetch_Valid;
  logic [NSTAGES-1:0] o_Stall;
  logic [NSTAGES-1:0] o_Flush;
  logic [NSTAGES-1:0] o_Valid;
  logic [1:0]         o_State;
  logic               o_Timeout;
  logic [15:0]        o_Stall_Cnt;

  modport master (
    output i_ICache_Miss, i_DCache_Miss, i_LoadUse, i_Redirect, i_Fetch_Valid,
    input  o_Stall, o_Flush, o_Valid, o_State, o_Timeout, o_Stall_Cnt
  );

  modport slave (
    input  i_ICache_Miss, i_DCache_Miss, i_LoadUse, i_Redirect, i_Fetch_Valid,
    output o_Stall, o_Flush, o_Valid, o_State, o_Timeout, o_Stall_Cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush generation, stage occupancy
// tracking, and a miss-wait watchdog that parks the pipe in ERR.
//
// state | meaning
// RUN   | normal flow, or a single-cycle hazard being handled
// IWAIT | waiting on an instruction-cache miss
// DWAIT | waiting on a data-cache miss
// ERR   | miss wait exceeded MISS_TO; everything frozen until reset
module pipe_ctrl #(
  parameter int NSTAGES     = 5,
  parameter int FLUSH_STAGE = 2,
  parameter int MISS_TO     = 255
) (
  input  logic       Clk,
  input  logic       Rst,
  pipe_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IWAIT = 2'd1,
    S_DWAIT = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam logic [15:0]        MISS_TO_C  = 16'(MISS_TO);
  localparam logic [NSTAGES-1:0] ONE_C      = NSTAGES'(1);
  localparam logic [NSTAGES-1:0] REDIR_MASK = ((ONE_C << (FLUSH_STAGE + 1)) - ONE_C) & ~ONE_C;
  localparam logic [NSTAGES-1:0] DM_STALL   = {1'b0, {(NSTAGES-1){1'b1}}};
  localparam logic [NSTAGES-1:0] DM_FLUSH   = {1'b1, {(NSTAGES-1){1'b0}}};

  state_e             state_q, state_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic [NSTAGES-1:0] valid_q, valid_d, valid_shift;
  logic [NSTAGES-1:0] stall, flush;
  logic               timeout_q, timeout_d;
  logic               in_wait;

  assign in_wait = (state_q == S_IWAIT) || (state_q == S_DWAIT);

  // Reset is folded in here so the datapath sees bubbles while Rst is low.
  always_comb begin
    stall = '0;
    flush = '0;
    if (!Rst) begin
      flush = '1;
    end else if (state_q == S_ERR) begin
      stall = '1;
    end else if (pif.i_DCache_Miss) begin
      stall = DM_STALL;
      flush = DM_FLUSH;
    end else if (pif.i_Redirect) begin
      flush = REDIR_MASK;
    end else if (pif.i_ICache_Miss) begin
      stall = NSTAGES'(1);
      flush = NSTAGES'(2);
    end else if (pif.i_LoadUse) begin
      stall = NSTAGES'(3);
      flush = NSTAGES'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_ERR) begin
      state_d = S_ERR;
    end else if (in_wait && (wait_cnt_q == MISS_TO_C)) begin
      state_d = S_ERR;
    end else if (pif.i_DCache_Miss) begin
      state_d = S_DWAIT;
    end else if (pif.i_Redirect) begin
      state_d = S_RUN;
    end else if (pif.i_ICache_Miss) begin
      state_d = S_IWAIT;
    end else begin
      state_d = S_RUN;
    end

    wait_cnt_d  = (in_wait && (state_d == state_q)) ? wait_cnt_q + 16'd1 : 16'd0;
    timeout_d   = (state_d == S_ERR) && (state_q != S_ERR);
    stall_cnt_d = (stall[0] && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    valid_shift = {valid_q[NSTAGES-2:0], pif.i_Fetch_Valid & ~pif.i_ICache_Miss};
    valid_d     = ~flush & ((stall & valid_q) | (~stall & valid_shift));
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      valid_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pif.o_Stall     = stall;
  assign pif.o_Flush     = flush;
  assign pif.o_Valid     = valid_q;
  assign pif.o_State     = state_q;
  assign pif.o_Timeout   = timeout_q;
  assign pif.o_Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table on a default instance, plus
// hand-written timeout and asynchronous-reset sequences on a MISS_TO=4 instance.
module tb_pipe_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 Clk = ~Clk;

  pipe_ctrl_if #(.NSTAGES(5)) pif0 ();
  pipe_ctrl_if #(.NSTAGES(5)) pif1 ();

  pipe_ctrl #(.NSTAGES(5), .FLUSH_STAGE(2), .MISS_TO(255)) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .pif (pif0)
  );

  pipe_ctrl #(.NSTAGES(5), .FLUSH_STAGE(2), .MISS_TO(4)) u_dut_to (
    .Clk (Clk),
    .Rst (Rst),
    .pif (pif1)
  );

  typedef struct {
    logic        imiss, dmiss, lu, redir, fv;
    logic [4:0]  stall, flush, valid;
    logic [1:0]  state;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic imiss, input logic dmiss, input logic lu,
                              input logic redir, input logic fv, input logic [4:0] stall,
                              input logic [4:0] flush, input logic [4:0] valid,
                              input logic [1:0] state, input logic [15:0] cnt);
    vec_t v;
    v.imiss = imiss; v.dmiss = dmiss; v.lu = lu; v.redir = redir; v.fv = fv;
    v.stall = stall; v.flush = flush; v.valid = valid; v.state = state; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    {pif0.i_ICache_Miss, pif0.i_DCache_Miss, pif0.i_LoadUse, pif0.i_Redirect, pif0.i_Fetch_Valid} = '0;
    {pif1.i_ICache_Miss, pif1.i_DCache_Miss, pif1.i_LoadUse, pif1.i_Redirect, pif1.i_Fetch_Valid} = '0;

    //       im dm lu rd fv  stall     flush     valid     st   cnt
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000,
                        (i < 5) ? 5'((1 << (i + 1)) - 1) : 5'b11111, 2'd0, 16'd0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'b01111, 5'b10000, 5'b01111, 2'd2, 16'd1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'b01111, 5'b10000, 5'b01111, 2'd2, 16'd2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'b01111, 5'b10000, 5'b01111, 2'd2, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b11111, 2'd0, 16'd3));
    vecs.push_back(mk(1, 0, 0, 1, 1, 5'b00000, 5'b00110, 5'b11000, 2'd0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b10001, 2'd0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00011, 2'd0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00111, 2'd0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b01111, 2'd0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b11111, 2'd0, 16'd3));
    vecs.push_back(mk(0, 0, 1, 0, 1, 5'b00011, 5'b00100, 5'b11011, 2'd0, 16'd4));
    vecs.push_back(mk(0, 1, 0, 1, 1, 5'b01111, 5'b10000, 5'b01011, 2'd2, 16'd5));
    vecs.push_back(mk(0, 0, 0, 1, 1, 5'b00000, 5'b00110, 5'b10001, 2'd0, 16'd5));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5'b00001, 5'b00010, 5'b00001, 2'd1, 16'd6));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5'b00001, 5'b00010, 5'b00001, 2'd1, 16'd7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00010, 2'd0, 16'd7));

    // Reset values while Rst is held low
    repeat (2) @(negedge Clk);
    check("rst_stall",   32'(pif0.o_Stall),     32'h00);
    check("rst_flush",   32'(pif0.o_Flush),     32'h1F);
    check("rst_valid",   32'(pif0.o_Valid),     32'h00);
    check("rst_state",   32'(pif0.o_State),     32'h0);
    check("rst_timeout", 32'(pif0.o_Timeout),   32'h0);
    check("rst_cnt",     32'(pif0.o_Stall_Cnt), 32'h0);
    Rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge Clk);
      pif0.i_ICache_Miss = vecs[i].imiss;
      pif0.i_DCache_Miss = vecs[i].dmiss;
      pif0.i_LoadUse     = vecs[i].lu;
      pif0.i_Redirect    = vecs[i].redir;
      pif0.i_Fetch_Valid = vecs[i].fv;
      #1;
      check($sformatf("v%0d_stall", i), 32'(pif0.o_Stall), 32'(vecs[i].stall));
      check($sformatf("v%0d_flush", i), 32'(pif0.o_Flush), 32'(vecs[i].flush));
      @(posedge Clk);
      #1;
      check($sformatf("v%0d_valid", i), 32'(pif0.o_Valid),     32'(vecs[i].valid));
      check($sformatf("v%0d_state", i), 32'(pif0.o_State),     32'(vecs[i].state));
      check($sformatf("v%0d_cnt", i),   32'(pif0.o_Stall_Cnt), 32'(vecs[i].cnt));
    end
    @(negedge Clk);
    {pif0.i_ICache_Miss, pif0.i_DCache_Miss, pif0.i_LoadUse, pif0.i_Redirect, pif0.i_Fetch_Valid} = '0;

    // Timeout: MISS_TO=4, ICache miss held 8 cycles; ERR after 5 cycles in IWAIT
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      pif1.i_ICache_Miss = 1'b1;
      #1;
      check($sformatf("to%0d_stall", n), 32'(pif1.o_Stall), (n <= 6) ? 32'h01 : 32'h1F);
      check($sformatf("to%0d_flush", n), 32'(pif1.o_Flush), (n <= 6) ? 32'h02 : 32'h00);
      @(posedge Clk);
      #1;
      check($sformatf("to%0d_state", n),   32'(pif1.o_State),   (n <= 5) ? 32'd1 : 32'd3);
      check($sformatf("to%0d_timeout", n), 32'(pif1.o_Timeout), (n == 6) ? 32'd1 : 32'd0);
    end
    @(negedge Clk);
    pif1.i_ICache_Miss = 1'b0;
    pif1.i_Redirect    = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("err_absorb_state", 32'(pif1.o_State), 32'd3);
    check("err_absorb_stall", 32'(pif1.o_Stall), 32'h1F);
    check("err_absorb_flush", 32'(pif1.o_Flush), 32'h00);
    pif1.i_Redirect = 1'b0;

    // Asynchronous reset from ERR, between clock edges
    #2;
    Rst = 1'b0;
    #1;
    check("arst_state",   32'(pif1.o_State),     32'd0);
    check("arst_stall",   32'(pif1.o_Stall),     32'h00);
    check("arst_flush",   32'(pif1.o_Flush),     32'h1F);
    check("arst_timeout", 32'(pif1.o_Timeout),   32'd0);
    check("arst_cnt",     32'(pif1.o_Stall_Cnt), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    pif1.i_Fetch_Valid = 1'b1;
    @(posedge Clk);
    #1;
    check("post_rst_valid", 32'(pif1.o_Valid), 32'h01);
    check("post_rst_state", 32'(pif1.o_State), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 5, number of pipeline stages; legal range 3..8; stage 0 = IF, stage NSTAGES-1 = WB.
REQ-002 SHALL have parameter FLUSH_STAGE, default 2, index of the stage that resolves branches; legal range 1..NSTAGES-2.
REQ-003 SHALL have parameter MISS_TO, default 255, maximum consecutive miss-wait cycles before error; legal range 1..65535.
REQ-004 Clk  input  1  single clock, rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-low.
REQ-006 i_ICache_Miss  input  1  level, instruction-cache miss in IF.
REQ-007 i_DCache_Miss  input  1  level, data-cache miss in stage NSTAGES-2.
REQ-008 i_LoadUse  input  1  level, load-use hazard detected in stage 1.
REQ-009 i_Redirect  input  1  level, branch/jump mispredict resolved in FLUSH_STAGE.
REQ-010 i_Fetch_Valid  input  1  IF presents a real instruction this cycle.
REQ-011 o_Stall  output  NSTAGES  bit k = register feeding stage k holds; bit 0 = PC.
REQ-012 o_Flush  output  NSTAGES  bit k = register feeding stage k loads a bubble.
REQ-013 o_Valid  output  NSTAGES  registered occupancy of each stage.
REQ-014 o_State  output  2  FSM state: 0 RUN, 1 IWAIT, 2 DWAIT, 3 ERR.
REQ-015 o_Timeout  output  1  one-cycle pulse on entry to ERR.
REQ-016 o_Stall_Cnt  output  16  count of cycles with o_Stall[0]=1, saturating.

Function
REQ-017 o_Stall/o_Flush SHALL be combinational from current inputs and state, effective on the same cycle a condition is asserted.
REQ-018 Priority SHALL be ERR > DCache_Miss > Redirect > ICache_Miss > LoadUse > none.
REQ-019 ERR: o_Stall all ones, o_Flush all zeros.
REQ-020 DCache_Miss: o_Stall[0..NSTAGES-2]=1, o_Flush[NSTAGES-1]=1; a concurrent Redirect is not acted on and must be held by its source.
REQ-021 Redirect: o_Flush[1..FLUSH_STAGE]=1, o_Stall all zeros (PC loads target); overrides concurrent ICache_Miss and LoadUse.
REQ-022 ICache_Miss: o_Stall[0]=1, o_Flush[1]=1, all other bits 0.
REQ-023 LoadUse: o_Stall[0]=o_Stall[1]=1, o_Flush[2]=1.
REQ-024 No condition: o_Stall and o_Flush all zeros.
REQ-025 Next state: DCache_Miss -> DWAIT; else Redirect -> RUN; else ICache_Miss -> IWAIT; else RUN; ERR is absorbing until reset.
REQ-026 Wait counter (16 bit) SHALL increment each cycle the next state equals the current wait state (IWAIT or DWAIT), clear otherwise.
REQ-027 When a wait state is occupied and the counter reaches MISS_TO, next state SHALL be ERR and o_Timeout pulse for exactly that transition cycle+1 (first ERR cycle).
REQ-028 o_Valid update each clock: bit k <= 0 if o_Flush[k]; else hold if o_Stall[k]; else bit k-1 (bit 0 takes i_Fetch_Valid & ~i_ICache_Miss).
REQ-029 o_Stall_Cnt SHALL increment when o_Stall[0]=1 and saturate at 16'hFFFF.

Reset
REQ-030 While Rst=0: o_State=RUN, o_Valid=0, wait counter=0, o_Stall_Cnt=0, o_Timeout=0, o_Stall all zeros, o_Flush all ones.
REQ-031 Reset asserted mid-miss or in ERR SHALL return to RUN asynchronously; first edge after release behaves as RUN with empty pipe.

Verification
REQ-032 Defaults, i_Fetch_Valid=1 for 6 cycles after reset -> o_Valid fills 00001,00011,...,11111; o_Stall=0, o_Flush=0.
REQ-033 Full pipe, i_DCache_Miss=1 for 3 cycles -> o_Stall=01111, o_Flush=10000 each cycle, o_State=2, o_Valid[4] cleared, o_Stall_Cnt=3.
REQ-034 i_Redirect and i_ICache_Miss high 1 cycle -> o_Flush=00110, o_Stall=00000, next o_State=0.
REQ-035 i_DCache_Miss and i_Redirect both high -> o_Stall=01111, o_Flush=10000; dropping DCache_Miss with Redirect held -> o_Flush=00110 next cycle.
REQ-036 MISS_TO=4, i_ICache_Miss held 8 cycles -> o_State=3 after 5 cycles in IWAIT, o_Timeout one pulse, o_Stall=11111 thereafter until Rst=0.
REQ-037 i_LoadUse 1 cycle with stages full -> o_Stall=00011, o_Flush=00100, o_Valid[2]=0 next cycle, stages 3..4 advance.
